// File: rtl/cpu_pkg.sv
// Shared opcode, ALU function, state and strobe definitions for the control sequencer.
package cpu_pkg;

    localparam int unsigned OPC_BITS = 5;
    localparam int unsigned ALU_BITS = 4;

    localparam logic [OPC_BITS-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_BITS-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_BITS-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_BITS-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_BITS-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_BITS-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_BITS-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_BITS-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_BITS-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPC_BITS-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPC_BITS-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_BITS-1:0] OP_HALT = 5'b11011;

    localparam logic [ALU_BITS-1:0] ALU_PASS = 4'd0;
    localparam logic [ALU_BITS-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALU_BITS-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALU_BITS-1:0] ALU_AND  = 4'd3;
    localparam logic [ALU_BITS-1:0] ALU_OR   = 4'd4;
    localparam logic [ALU_BITS-1:0] ALU_MUL  = 4'd5;
    localparam logic [ALU_BITS-1:0] ALU_DIV  = 4'd6;

    // T states are numbered so that the step index is the encoding minus one.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_T7     = 4'd8,
        S_HALTED = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_MULDIV, CLS_MFHI, CLS_MFLO, CLS_LD, CLS_ST, CLS_HALT
    } op_class_e;

    typedef struct packed {
        logic pco, pci, inc_pc, iri;
        logic mari, mdri, mdro, mem_read, mem_write;
        logic gra, grb, grc, rin, rout, baout, csigno;
        logic ryi, rzi, rzlo, rzho;
        logic hii, hio, loi, loo;
    } strobes_t;

    function automatic op_class_e op_class(input logic [OPC_BITS-1:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_ALU;
            OP_MUL, OP_DIV:                return CLS_MULDIV;
            OP_MFHI:                       return CLS_MFHI;
            OP_MFLO:                       return CLS_MFLO;
            OP_LD:                         return CLS_LD;
            OP_ST:                         return CLS_ST;
            OP_HALT:                       return CLS_HALT;
            default:                       return CLS_NOP;
        endcase
    endfunction

    function automatic logic [ALU_BITS-1:0] alu_code(input logic [OPC_BITS-1:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; done is high once the count has reached zero.
module step_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch in T0-T2, per-opcode execute in T3-T7, Moore strobe decode
// with mdri following mem_ready in the memory-wait steps.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OPC_W      = 5,
    parameter int unsigned ALU_OP_W   = 4,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned STEP_W     = 3
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic [2:0]          pc_ctl,
    output logic                iri,
    output logic [4:0]          mem_ctl,
    output logic [6:0]          rf_ctl,
    output logic                ryi,
    output logic [2:0]          z_ctl,
    output logic [3:0]          hilo_ctl,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [STEP_W-1:0]   step,
    output logic                busy,
    output logic                halted
);

    localparam int unsigned CNT_W = $clog2(MULDIV_LAT) + 1;

    state_e                state_q, state_d;
    state_e                boundary;
    op_class_e             cls;
    logic [ALU_BITS-1:0]   alu_fn, alu_sel;
    logic                  timer_load, timer_dec, timer_done;
    strobes_t              s;
    logic                  unused_ir;

    assign cls       = op_class(OPC_BITS'(ir[31 -: OPC_W]));
    assign alu_fn    = alu_code(OPC_BITS'(ir[31 -: OPC_W]));
    assign unused_ir = ^ir[31-OPC_W:0];
    assign boundary  = run ? S_T0 : S_IDLE;
    assign timer_dec = (state_q == S_T4);

    step_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clock   (clock),
        .clear   (clear),
        .load    (timer_load),
        .load_val(CNT_W'(MULDIV_LAT - 1)),
        .dec     (timer_dec),
        .done    (timer_done)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s          = '0;
        alu_sel    = ALU_PASS;
        timer_load = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0: begin
                s.pco = 1'b1; s.mari = 1'b1; s.inc_pc = 1'b1; s.rzi = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                s.rzlo = 1'b1; s.pci = 1'b1; s.mem_read = 1'b1; s.mdri = mem_ready;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                s.mdro = 1'b1; s.iri = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    CLS_ALU:        begin s.grb = 1'b1; s.rout = 1'b1; s.ryi = 1'b1; end
                    CLS_LD, CLS_ST: begin s.grb = 1'b1; s.baout = 1'b1; s.ryi = 1'b1; end
                    CLS_MULDIV: begin
                        s.gra = 1'b1; s.rout = 1'b1; s.ryi = 1'b1;
                        timer_load = 1'b1;
                    end
                    CLS_MFHI: begin s.hio = 1'b1; s.gra = 1'b1; s.rin = 1'b1; state_d = boundary; end
                    CLS_MFLO: begin s.loo = 1'b1; s.gra = 1'b1; s.rin = 1'b1; state_d = boundary; end
                    CLS_HALT: state_d = S_HALTED;
                    default:  state_d = boundary;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    CLS_ALU: begin
                        s.grc = 1'b1; s.rout = 1'b1; s.rzi = 1'b1; alu_sel = alu_fn;
                    end
                    CLS_MULDIV: begin
                        s.grb = 1'b1; s.rout = 1'b1; s.rzi = 1'b1; alu_sel = alu_fn;
                        if (!timer_done) state_d = S_T4;
                    end
                    CLS_LD, CLS_ST: begin s.csigno = 1'b1; s.rzi = 1'b1; alu_sel = ALU_ADD; end
                    default: state_d = boundary;
                endcase
            end
            S_T5: begin
                state_d = S_T6;
                case (cls)
                    CLS_ALU:        begin s.rzlo = 1'b1; s.gra = 1'b1; s.rin = 1'b1; state_d = boundary; end
                    CLS_MULDIV:     begin s.rzlo = 1'b1; s.loi = 1'b1; end
                    CLS_LD, CLS_ST: begin s.rzlo = 1'b1; s.mari = 1'b1; end
                    default:        state_d = boundary;
                endcase
            end
            S_T6: begin
                state_d = S_T7;
                case (cls)
                    CLS_MULDIV: begin s.rzho = 1'b1; s.hii = 1'b1; state_d = boundary; end
                    CLS_LD: begin
                        s.mem_read = 1'b1; s.mdri = mem_ready;
                        if (!mem_ready) state_d = S_T6;
                    end
                    // mem_read low selects the internal bus into MDR
                    CLS_ST:  begin s.gra = 1'b1; s.rout = 1'b1; s.mdri = 1'b1; end
                    default: state_d = boundary;
                endcase
            end
            S_T7: begin
                state_d = boundary;
                case (cls)
                    CLS_LD: begin s.mdro = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
                    CLS_ST: begin
                        s.mem_write = 1'b1;
                        if (!mem_ready) state_d = S_T7;
                    end
                    default: ;
                endcase
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    assign pc_ctl   = {s.pco, s.pci, s.inc_pc};
    assign iri      = s.iri;
    assign mem_ctl  = {s.mari, s.mdri, s.mdro, s.mem_read, s.mem_write};
    assign rf_ctl   = {s.gra, s.grb, s.grc, s.rin, s.rout, s.baout, s.csigno};
    assign ryi      = s.ryi;
    assign z_ctl    = {s.rzi, s.rzlo, s.rzho};
    assign hilo_ctl = {s.hii, s.hio, s.loi, s.loo};
    assign alu_op   = ALU_OP_W'(alu_sel);
    assign busy     = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted   = (state_q == S_HALTED);
    assign step     = busy ? STEP_W'(4'(state_q) - 4'd1) : '0;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized bench for control_sequencer against a step-table reference model.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam int unsigned LAT = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    localparam logic [23:0] PCO = 24'd1 << 23, PCI = 24'd1 << 22, INC = 24'd1 << 21;
    localparam logic [23:0] IRI = 24'd1 << 20, MARI = 24'd1 << 19, MDRI = 24'd1 << 18;
    localparam logic [23:0] MDRO = 24'd1 << 17, MRD = 24'd1 << 16, MWR = 24'd1 << 15;
    localparam logic [23:0] GRA = 24'd1 << 14, GRB = 24'd1 << 13, GRC = 24'd1 << 12;
    localparam logic [23:0] RIN = 24'd1 << 11, ROUT = 24'd1 << 10, BAOUT = 24'd1 << 9;
    localparam logic [23:0] CSIGNO = 24'd1 << 8, RYI = 24'd1 << 7, RZI = 24'd1 << 6;
    localparam logic [23:0] RZLO = 24'd1 << 5, RZHO = 24'd1 << 4, HII = 24'd1 << 3;
    localparam logic [23:0] HIO = 24'd1 << 2, LOI = 24'd1 << 1, LOO = 24'd1;

    logic        clock, clear, run, mem_ready;
    logic [31:0] ir;
    logic [2:0]  pc_ctl, z_ctl, step;
    logic        iri, ryi, busy, halted;
    logic [4:0]  mem_ctl;
    logic [6:0]  rf_ctl;
    logic [3:0]  hilo_ctl, alu_op;
    logic [23:0] got;

    control_sequencer #(
        .OPC_W(5), .ALU_OP_W(4), .MULDIV_LAT(LAT), .STEP_W(3)
    ) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .pc_ctl(pc_ctl), .iri(iri), .mem_ctl(mem_ctl), .rf_ctl(rf_ctl), .ryi(ryi),
        .z_ctl(z_ctl), .hilo_ctl(hilo_ctl), .alu_op(alu_op), .step(step),
        .busy(busy), .halted(halted)
    );

    assign got = {pc_ctl, iri, mem_ctl, rf_ctl, ryi, z_ctl, hilo_ctl};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: each instruction is a list of steps; wk=1 waits on ready with
    // mdri following ready, wk=2 waits on ready without mdri.
    typedef struct {
        int          stp;
        logic [23:0] strb;
        logic [3:0]  alu;
        int          wk;
        bit          halt;
    } ent_t;

    ent_t seq[$];
    int   pos  = 0;
    int   mode = M_IDLE;

    function automatic void put(input int stp, input logic [23:0] sb, input logic [3:0] a,
                                input int wk, input bit h);
        ent_t e;
        e.stp = stp; e.strb = sb; e.alu = a; e.wk = wk; e.halt = h;
        seq.push_back(e);
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] opc);
        if (opc == OP_ADD) return ALU_ADD;
        if (opc == OP_SUB) return ALU_SUB;
        if (opc == OP_AND) return ALU_AND;
        if (opc == OP_OR)  return ALU_OR;
        if (opc == OP_MUL) return ALU_MUL;
        return ALU_DIV;
    endfunction

    function automatic void start_fetch();
        seq.delete();
        put(0, PCO | MARI | INC | RZI, ALU_PASS, 0, 1'b0);
        put(1, RZLO | PCI | MRD, ALU_PASS, 1, 1'b0);
        put(2, MDRO | IRI, ALU_PASS, 0, 1'b0);
        pos = 0;
    endfunction

    function automatic void add_exec(input logic [4:0] opc);
        if (opc == OP_ADD || opc == OP_SUB || opc == OP_AND || opc == OP_OR) begin
            put(3, GRB | ROUT | RYI, ALU_PASS, 0, 1'b0);
            put(4, GRC | ROUT | RZI, alu_of(opc), 0, 1'b0);
            put(5, RZLO | GRA | RIN, ALU_PASS, 0, 1'b0);
        end else if (opc == OP_MUL || opc == OP_DIV) begin
            put(3, GRA | ROUT | RYI, ALU_PASS, 0, 1'b0);
            for (int k = 0; k < int'(LAT); k++) put(4, GRB | ROUT | RZI, alu_of(opc), 0, 1'b0);
            put(5, RZLO | LOI, ALU_PASS, 0, 1'b0);
            put(6, RZHO | HII, ALU_PASS, 0, 1'b0);
        end else if (opc == OP_MFHI) begin
            put(3, HIO | GRA | RIN, ALU_PASS, 0, 1'b0);
        end else if (opc == OP_MFLO) begin
            put(3, LOO | GRA | RIN, ALU_PASS, 0, 1'b0);
        end else if (opc == OP_LD || opc == OP_ST) begin
            put(3, GRB | BAOUT | RYI, ALU_PASS, 0, 1'b0);
            put(4, CSIGNO | RZI, ALU_ADD, 0, 1'b0);
            put(5, RZLO | MARI, ALU_PASS, 0, 1'b0);
            if (opc == OP_LD) begin
                put(6, MRD, ALU_PASS, 1, 1'b0);
                put(7, MDRO | GRA | RIN, ALU_PASS, 0, 1'b0);
            end else begin
                put(6, GRA | ROUT | MDRI, ALU_PASS, 0, 1'b0);
                put(7, MWR, ALU_PASS, 2, 1'b0);
            end
        end else begin
            put(3, 24'd0, ALU_PASS, 0, opc == OP_HALT);
        end
    endfunction

    always @(posedge clock) begin : model
        ent_t e;
        if (clear) begin
            mode = M_IDLE;
            pos  = 0;
            seq.delete();
        end else if (mode == M_IDLE) begin
            if (run) begin start_fetch(); mode = M_RUN; end
        end else if (mode == M_RUN) begin
            e = seq[pos];
            if (e.wk == 0 || mem_ready) begin
                if (seq.size() == 3 && pos == 2) add_exec(ir[31:27]);
                if (pos == seq.size() - 1) begin
                    if (e.halt)   mode = M_HALT;
                    else if (run) start_fetch();
                    else          mode = M_IDLE;
                end else begin
                    pos++;
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [23:0] es;
        logic [3:0]  ea;
        int          est;
        ent_t        e;
        if (chk_en) begin
            es = 24'd0; ea = ALU_PASS; est = 0;
            if (mode == M_RUN) begin
                e   = seq[pos];
                es  = e.strb | ((e.wk == 1 && mem_ready) ? MDRI : 24'd0);
                ea  = e.alu;
                est = e.stp;
            end
            chk("strobes", 32'(got), 32'(es));
            chk("alu_op", 32'(alu_op), 32'(ea));
            chk("step", 32'(step), 32'(est));
            chk("busy", 32'(busy), 32'(mode == M_RUN));
            chk("halted", 32'(halted), 32'(mode == M_HALT));
        end
    end

    task automatic drive(input logic c, input logic r, input logic rdy);
        @(posedge clock);
        #1;
        clear = c; run = r; mem_ready = rdy;
    endtask

    int          cnt [8];
    int          rzi_cnt [8];
    logic [23:0] sor [8];
    int          total;
    bit          fin;

    // Start one instruction from IDLE with ready tied high; run stays high for `hold` busy cycles.
    task automatic exec_instr(input logic [4:0] opc, input int hold);
        ir = {opc, 27'($urandom)};
        for (int k = 0; k < 8; k++) begin cnt[k] = 0; rzi_cnt[k] = 0; sor[k] = 24'd0; end
        total = 0; fin = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40 && !fin; i++) begin
            drive(1'b0, logic'(i < hold), 1'b1);
            @(negedge clock);
            if (!busy) fin = 1'b1;
            else begin
                total++;
                cnt[step]++;
                sor[step] |= got;
                if (z_ctl[2]) rzi_cnt[step]++;
            end
        end
        chk("instr_completes", 32'(fin), 32'd1);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] ops [14];
        logic [4:0] o;
        ops = '{OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV,
                OP_MFHI, OP_MFLO, OP_NOP, OP_HALT, 5'b00001, 5'b11111};
        o = ops[$urandom_range(0, 13)];
        if (o == OP_HALT && $urandom_range(0, 3) != 0) o = OP_NOP;
        return {o, 27'($urandom)};
    endfunction

    initial begin
        bit found;
        clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        @(negedge clock);
        chk("reset_strobes", 32'(got), 32'd0);
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_alu", 32'(alu_op), 32'(ALU_PASS));
        repeat (3) begin
            drive(1'b0, 1'b0, 1'b1);
            @(negedge clock);
            chk("idle_hold", 32'(busy), 32'd0);
        end

        // MFLO twice back to back, second one ends in IDLE
        exec_instr(OP_MFLO, 4);
        chk("mflo_cycles", 32'(total), 32'd8);
        chk("mflo_t0_count", 32'(cnt[0]), 32'd2);
        chk("mflo_t3", 32'(sor[3]), 32'(LOO | GRA | RIN));

        // ADD with ready low for the first three T1 cycles
        ir = {OP_ADD, 27'($urandom)};
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        chk("add_t0_step", 32'(step), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, logic'(i == 3));
            @(negedge clock);
            chk("add_t1_step", 32'(step), 32'd1);
            chk("add_t1_pci", 32'(pc_ctl[1]), 32'd1);
            chk("add_t1_mdri", 32'(mem_ctl[3]), 32'(i == 3));
        end
        for (int k = 2; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            @(negedge clock);
            chk("add_step", 32'(step), 32'(k));
            if (k == 4) chk("add_alu", 32'(alu_op), 32'(ALU_ADD));
        end
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        chk("add_end_idle", 32'(busy), 32'd0);

        exec_instr(OP_MUL, 0);
        chk("mul_cycles", 32'(total), 32'(6 + LAT));
        chk("mul_t4_cycles", 32'(cnt[4]), 32'(LAT));
        chk("mul_t4_rzi", 32'(rzi_cnt[4]), 32'(LAT));
        chk("mul_t5", 32'(sor[5]), 32'(RZLO | LOI));
        chk("mul_t6", 32'(sor[6]), 32'(RZHO | HII));

        exec_instr(OP_LD, 5);
        chk("ld_cycles", 32'(total), 32'd8);
        chk("ld_t7", 32'(sor[7]), 32'(MDRO | GRA | RIN));

        exec_instr(OP_ST, 0);
        chk("st_cycles", 32'(total), 32'd8);
        chk("st_t6", 32'(sor[6]), 32'(GRA | ROUT | MDRI));

        // HALT holds until clear
        ir = {OP_HALT, 27'd0};
        drive(1'b0, 1'b1, 1'b1);
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        @(negedge clock);
        chk("halt_t3", 32'(step), 32'd3);
        repeat (3) begin
            drive(1'b0, 1'b1, 1'b1);
            @(negedge clock);
            chk("halted_flag", 32'(halted), 32'd1);
            chk("halted_busy", 32'(busy), 32'd0);
        end
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        chk("halt_cleared", 32'(halted), 32'd0);

        // clear while ST waits in T7
        ir = {OP_ST, 27'($urandom)};
        drive(1'b0, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            @(negedge clock);
            if (busy && step == 3'd6) found = 1'b1;
        end
        chk("st_reach_t6", 32'(found), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("st_t7_wait", 32'(mem_ctl[0]), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("st_t7_still", 32'(step), 32'd7);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        chk("st_clear_write", 32'(mem_ctl[0]), 32'd0);
        chk("st_clear_step", 32'(step), 32'd0);
        chk("st_clear_busy", 32'(busy), 32'd0);

        // random phase; ir only changes outside the execute steps
        for (int c = 0; c < 4000; c++) begin
            @(posedge clock);
            #1;
            clear     = (mode == M_HALT) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
            run       = ($urandom_range(0, 4) != 0);
            mem_ready = ($urandom_range(0, 9) < 6);
            if ((mode != M_RUN || pos < 3) && $urandom_range(0, 1) == 1) ir = rand_ir();
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
